ga23_layer_shifter: RTL and testbench

Parametrised row-queued pixel shifter for one GA23 background layer. It accepts planar tile rows from the tile fetcher through a small ready/load queue and serialises them at `ce_pix` rate with fine-scroll alignment. It emits palette-indexed colour, priority and an opaque flag per pixel, and sits between the layer fetch FSM and the layer mixer.

---
 rtl/ga23_pkg.sv | 38 +++
 rtl/ga23_row_fifo.sv | 86 ++++++++
 rtl/ga23_layer_shifter.sv | 131 +++++++++++++
 tb/tb_ga23_layer_shifter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ga23_pkg.sv
// Shared types for the GA23 background layer shifter: queued row entry layout,
// the transparent row, and planar-to-chunky row unpacking.
package ga23_pkg;

    localparam int GA23_BPP    = 4;
    localparam int GA23_TILE_W = 8;
    localparam int GA23_PAL_W  = 4;
    localparam int GA23_PRIO_W = 2;

    typedef logic [GA23_BPP-1:0]        pixel_t;
    typedef pixel_t [GA23_TILE_W-1:0]   row_pixels_t;

    // pixels[0] is the leftmost (first displayed) pixel of the row.
    typedef struct packed {
        row_pixels_t             pixels;
        logic [GA23_PAL_W-1:0]   palette;
        logic [GA23_PRIO_W-1:0]  prio;
    } shifter_entry_t;

    localparam shifter_entry_t TRANSPARENT_ENTRY = '0;

    function automatic row_pixels_t unpack_row(
        input logic [GA23_BPP*GA23_TILE_W-1:0] row,
        input logic                            reverse
    );
        row_pixels_t px;
        int          pos;
        px = '0;
        for (int i = 0; i < GA23_TILE_W; i++) begin
            pos = reverse ? i : (GA23_TILE_W - 1 - i);
            for (int p = 0; p < GA23_BPP; p++) begin
                px[i][p] = row[p*GA23_TILE_W + pos];
            end
        end
        return px;
    endfunction

endpackage

// File: rtl/ga23_row_fifo.sv
// Small circular row queue with synchronous clear; clear takes precedence
// over pop, and a coincident push lands in the freshly emptied queue.
module ga23_row_fifo
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = logic [7:0]
)
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  entry_t                     wdata,
    output entry_t                     rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push_ok, pop_ok;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = push ? next_ptr('0) : '0;
            count_d  = push ? CNT_W'(1) : '0;
            if (push) begin
                mem_d[0] = wdata;
            end
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = next_ptr(wr_ptr_q);
            end
            if (pop_ok) begin
                rd_ptr_d = next_ptr(rd_ptr_q);
            end
            if (push_ok && !pop_ok) begin
                count_d = count_q + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // Row storage carries no reset; only the pointers and occupancy do.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ga23_layer_shifter.sv
// GA23 background layer pixel shifter: queues unpacked tile rows and serialises
// them at ce_pix with fine scroll. Entry layout follows the ga23_pkg constants.
module ga23_layer_shifter
    import ga23_pkg::*;
#(
    parameter int BPP    = GA23_BPP,
    parameter int TILE_W = GA23_TILE_W,
    parameter int PAL_W  = GA23_PAL_W,
    parameter int PRIO_W = GA23_PRIO_W,
    parameter int DEPTH  = 2
)
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ce_pix,
    input  logic                       line_start,
    input  logic [$clog2(TILE_W)-1:0]  offset,
    input  logic                       load,
    input  logic                       reverse,
    input  logic [BPP*TILE_W-1:0]      row,
    input  logic [PAL_W-1:0]           palette,
    input  logic [PRIO_W-1:0]          prio,
    output logic                       load_ready,
    output logic [PAL_W+BPP-1:0]       color_out,
    output logic [PRIO_W-1:0]          prio_out,
    output logic                       opaque_out,
    output logic                       underrun,
    output logic                       overflow
);
    localparam int CNT_W  = $clog2(TILE_W);
    localparam int FCNT_W = $clog2(DEPTH+1);

    shifter_entry_t       cur_q, cur_d;
    shifter_entry_t       head, wr_entry;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]     phase;
    logic [PAL_W+BPP-1:0] color_q, color_d;
    logic [PRIO_W-1:0]    prio_q, prio_d;
    logic                 opaque_q, opaque_d;
    logic                 underrun_q, underrun_d;
    logic                 overflow_q, overflow_d;
    logic                 due;
    logic                 fifo_push, fifo_pop, fifo_clear;
    logic                 fifo_full, fifo_empty;
    logic [FCNT_W-1:0]    fifo_count;

    assign wr_entry = '{pixels: unpack_row(row, reverse), palette: palette, prio: prio};
    assign phase    = cnt_q + offset;
    assign due      = &phase;

    ga23_row_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (shifter_entry_t)
    ) u_row_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (fifo_clear),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (wr_entry),
        .rdata (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        cur_d      = cur_q;
        cnt_d      = cnt_q;
        color_d    = color_q;
        prio_d     = prio_q;
        opaque_d   = opaque_q;
        underrun_d = underrun_q;
        overflow_d = overflow_q;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        fifo_clear = 1'b0;
        if (ce_pix) begin
            underrun_d = 1'b0;
            overflow_d = 1'b0;
            if (line_start) begin
                fifo_clear = 1'b1;
                fifo_push  = load;
                cnt_d      = '0;
                cur_d      = TRANSPARENT_ENTRY;
            end else begin
                cnt_d        = cnt_q + 1'b1;
                cur_d.pixels = cur_q.pixels >> GA23_BPP;
                if (due) begin
                    fifo_pop   = !fifo_empty;
                    underrun_d = fifo_empty;
                    cur_d      = fifo_empty ? TRANSPARENT_ENTRY : head;
                end
                // Occupancy is judged before this edge's pop, so a pop frees a full slot.
                fifo_push  = load && (!fifo_full || fifo_pop);
                overflow_d = load && fifo_full && !fifo_pop;
            end
            color_d  = {cur_d.palette, cur_d.pixels[0]};
            prio_d   = cur_d.prio;
            opaque_d = |cur_d.pixels[0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_q      <= TRANSPARENT_ENTRY;
            cnt_q      <= '0;
            color_q    <= '0;
            prio_q     <= '0;
            opaque_q   <= 1'b0;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            cur_q      <= cur_d;
            cnt_q      <= cnt_d;
            color_q    <= color_d;
            prio_q     <= prio_d;
            opaque_q   <= opaque_d;
            underrun_q <= underrun_d;
            overflow_q <= overflow_d;
        end
    end

    assign load_ready = (fifo_count != FCNT_W'(DEPTH));
    assign color_out  = color_q;
    assign prio_out   = prio_q;
    assign opaque_out = opaque_q;
    assign underrun   = underrun_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_ga23_layer_shifter.sv
// Scoreboard bench for ga23_layer_shifter: each driven cycle queues its expected
// outputs; a monitor pops one entry after every clock edge and compares.
module tb_ga23_layer_shifter;

    logic        clk = 1'b0;
    logic        reset, ce_pix, line_start, load, reverse;
    logic [2:0]  offset;
    logic [31:0] row;
    logic [3:0]  palette;
    logic [1:0]  prio;
    logic        load_ready;
    logic [7:0]  color_out;
    logic [1:0]  prio_out;
    logic        opaque_out, underrun, overflow;

    always #5 clk = ~clk;

    ga23_layer_shifter dut (
        .clk        (clk),
        .reset      (reset),
        .ce_pix     (ce_pix),
        .line_start (line_start),
        .offset     (offset),
        .load       (load),
        .reverse    (reverse),
        .row        (row),
        .palette    (palette),
        .prio       (prio),
        .load_ready (load_ready),
        .color_out  (color_out),
        .prio_out   (prio_out),
        .opaque_out (opaque_out),
        .underrun   (underrun),
        .overflow   (overflow)
    );

    // mask bits: 0 color, 1 prio, 2 opaque, 3 underrun, 4 overflow, 5 load_ready
    typedef struct {
        string      name;
        logic [7:0] color;
        logic [1:0] prio;
        logic       opq;
        logic       und;
        logic       ovf;
        logic       rdy;
        logic [5:0] mask;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    logic [2:0] cur_ofs = 3'd0;

    localparam logic [31:0] ROW_A = 32'hF0CCAA00;
    localparam logic [31:0] ROW_C = 32'hF0CC0F00;
    // Hand-derived display-order pixels of ROW_A and ROW_C, unflipped.
    logic [3:0] a_pix [8] = '{4'hE, 4'hC, 4'hA, 4'h8, 4'h6, 4'h4, 4'h2, 4'h0};
    logic [3:0] c_pix [8] = '{4'hC, 4'hC, 4'h8, 4'h8, 4'h6, 4'h6, 4'h2, 4'h2};

    function automatic void chk(input string nm, input logic [7:0] act, input logic [7:0] ex);
        checks++;
        if (act !== ex) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, ex);
        end
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.mask[0]) chk({e.name, ".color"},  color_out,          e.color);
                if (e.mask[1]) chk({e.name, ".prio"},   {6'd0, prio_out},   {6'd0, e.prio});
                if (e.mask[2]) chk({e.name, ".opaque"}, {7'd0, opaque_out}, {7'd0, e.opq});
                if (e.mask[3]) chk({e.name, ".underrun"}, {7'd0, underrun}, {7'd0, e.und});
                if (e.mask[4]) chk({e.name, ".overflow"}, {7'd0, overflow}, {7'd0, e.ovf});
                if (e.mask[5]) chk({e.name, ".load_ready"}, {7'd0, load_ready}, {7'd0, e.rdy});
            end
        end
    end

    task automatic drive(input logic rs, input logic ce, input logic ls, input logic ld,
                         input logic rv, input logic [31:0] r, input logic [3:0] pal,
                         input logic [1:0] pr);
        @(negedge clk);
        reset      = rs;
        ce_pix     = ce;
        line_start = ls;
        load       = ld;
        reverse    = rv;
        row        = r;
        palette    = pal;
        prio       = pr;
        offset     = cur_ofs;
    endtask

    task automatic idle();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 2'd0);
    endtask

    task automatic exq(input string nm, input logic [7:0] c, input logic [1:0] p,
                       input logic o, input logic u, input logic v, input logic r,
                       input logic [5:0] m);
        exp_t e;
        e.name = nm; e.color = c; e.prio = p; e.opq = o;
        e.und = u; e.ovf = v; e.rdy = r; e.mask = m;
        exp_q.push_back(e);
    endtask

    task automatic expx(input string nm, input logic [7:0] c, input logic [1:0] p);
        exq(nm, c, p, (c[3:0] != 4'h0), 1'b0, 1'b0, 1'b0, 6'h1F);
    endtask

    task automatic exnone();
        exq("skip", 8'h0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00);
    endtask

    initial begin : stimulus
        reset = 1'b1; ce_pix = 1'b0; line_start = 1'b0; load = 1'b0; reverse = 1'b0;
        offset = 3'd0; row = '0; palette = '0; prio = '0;

        // Reset state.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 2'd0);
        exq("reset", 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 6'h3F);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, ROW_A, 4'h3, 2'd1);
        exq("reset_hold", 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 6'h3F);

        // Unflipped, flipped and second pattern rows back to back.
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, ROW_A, 4'h3, 2'd1);
        exq("ls_load", 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 6'h3F);
        for (int k = 1; k < 8; k++) begin
            idle();
            expx("pre_pop", 8'h00, 2'd0);
        end
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 1'b1, 1'b0, (k == 1), 1'b1, ROW_A, 4'h3, 2'd2);
            expx("unflip", {4'h3, a_pix[k]}, 2'd1);
        end
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 1'b1, 1'b0, (k == 1), 1'b0, ROW_C, 4'h3, 2'd3);
            expx("flip", {4'h3, a_pix[7-k]}, 2'd2);
        end
        for (int k = 0; k < 8; k++) begin
            idle();
            expx("row_c", {4'h3, c_pix[k]}, 2'd3);
        end

        // Underrun, then underrun coincident with a load.
        idle();
        exq("underrun", 8'h00, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 6'h3F);
        for (int k = 1; k < 8; k++) begin
            idle();
            expx("und_blank", 8'h00, 2'd0);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, ROW_A, 4'h7, 2'd0);
        exq("und_load", 8'h00, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 6'h3F);
        for (int k = 1; k < 8; k++) begin
            idle();
            expx("und_load_wait", 8'h00, 2'd0);
        end
        idle();
        expx("und_load_pop", 8'h7E, 2'd0);
        for (int k = 1; k < 8; k++) begin
            idle();
            exnone();
        end

        // Fine scroll of 5 with a two-cycle ce_pix stall.
        cur_ofs = 3'd5;
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, ROW_C, 4'h5, 2'd2);
        exq("scroll_ls", 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 6'h3F);
        for (int k = 1; k < 3; k++) begin
            idle();
            expx("scroll_wait", 8'h00, 2'd0);
        end
        idle();
        expx("scroll_pop", {4'h5, c_pix[0]}, 2'd2);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, ROW_A, 4'h6, 2'd1);
        expx("scroll_px1", {4'h5, c_pix[1]}, 2'd2);
        idle();
        expx("scroll_px2", {4'h5, c_pix[2]}, 2'd2);
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 2'd0);
            expx("stall_hold", {4'h5, c_pix[2]}, 2'd2);
        end
        for (int k = 3; k < 8; k++) begin
            idle();
            expx("scroll_px", {4'h5, c_pix[k]}, 2'd2);
        end
        for (int k = 0; k < 8; k++) begin
            idle();
            expx("scroll_next", {4'h6, a_pix[k]}, 2'd1);
        end

        // Queue limits.
        cur_ofs = 3'd0;
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 2'd0);
        exq("q_ls", 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 6'h3F);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, ROW_A, 4'h1, 2'd1);
        exq("q_load1", 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 6'h39);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, ROW_A, 4'h2, 2'd2);
        exq("q_full", 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h39);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, ROW_A, 4'h7, 2'd3);
        exq("q_overflow", 8'h00, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 6'h39);
        idle();
        exq("q_ovf_end", 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h39);
        for (int k = 5; k < 8; k++) begin
            idle();
            exq("q_wait", 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h39);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, ROW_A, 4'h4, 2'd1);
        exq("q_load_pop", 8'h1E, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 6'h3F);
        for (int k = 1; k < 8; k++) begin
            idle();
            exq("q_hold", 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h20);
        end
        idle();
        exq("q_pop2", 8'h2E, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 6'h3F);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, ROW_A, 4'h5, 2'd0);
        exq("q_refill", 8'h2C, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 6'h3F);
        idle();
        exq("q_mid", 8'h2A, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 6'h3F);

        // Reset mid-row with two rows queued.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 2'd0);
        exq("reset_mid", 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 6'h3F);

        // line_start with a coincident load leaves exactly one row queued.
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, ROW_A, 4'h6, 2'd3);
        exq("ls_load_occ", 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 6'h3F);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, ROW_C, 4'h5, 2'd0);
        exq("ls_load_occ1", 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h3F);
        for (int k = 2; k < 8; k++) begin
            idle();
            exnone();
        end
        idle();
        exq("ls_load_pop", 8'h6E, 2'd3, 1'b1, 1'b0, 1'b0, 1'b1, 6'h3F);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, ROW_C, 4'h1, 2'd0);
        exq("ls_flush", 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 6'h3F);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, ROW_C, 4'h2, 2'd0);
        exq("ls_flush_occ", 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h3F);
        for (int k = 2; k < 8; k++) begin
            idle();
            exnone();
        end
        idle();
        exq("ls_flush_pop", 8'h1C, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 6'h3F);

        idle();
        exnone();
        repeat (3) @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
